snoop_responder: RTL and testbench

- Per-core snooping agent at the far end of the shared coherence bus.
- When the other core owns the bus, it takes the forwarded operation and address and looks up its own L1 tag/state/data array through a synchronous-read port.
- It answers with a hit indication, supplied data and a flush (writeback) request, then updates the local MESI state.
- It sits between the bus controller's per-core outputs and the core's cache array.

---
 rtl/coh_pkg.sv | 58 +++++
 rtl/snoop_responder.sv | 151 +++++++++++++++
 tb/tb_snoop_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coh_pkg.sv
// Shared coherence-bus types and the MESI snoop transition rule used by the snooping agent.
package coh_pkg;

  typedef enum logic [1:0] {
    NOP      = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_UPGR = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    SNP_IDLE,
    SNP_LOOKUP,
    SNP_RESPOND,
    SNP_RELEASE
  } snp_state_t;

  typedef struct packed {
    mesi_t new_state;
    logic  flush;
    logic  err;
  } mesi_res_t;

  // Remote-snoop transition for a line already known to be present; I stays I.
  function automatic mesi_res_t mesi_next(input bus_op_t op, input mesi_t st);
    mesi_res_t r;
    r.new_state = st;
    r.flush     = 1'b0;
    r.err       = 1'b0;
    if (st != MESI_I) begin
      case (op)
        BUS_RD: begin
          r.new_state = MESI_S;
          r.flush     = (st == MESI_M);
        end
        BUS_RDX: begin
          r.new_state = MESI_I;
          r.flush     = (st == MESI_M);
        end
        BUS_UPGR: begin
          // An upgrade is only legal while the line is shared everywhere.
          r.new_state = MESI_I;
          r.err       = (st == MESI_E) || (st == MESI_M);
        end
        default: r.new_state = st;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/snoop_responder.sv
// Snooping agent: looks up the local L1 for forwarded bus ops, answers hit/data/flush
// and writes back the new MESI state.
module snoop_responder
  import coh_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grant,
  input  logic [1:0]       bus_operation_in,
  input  logic [31:0]      bus_address_in,
  output logic             cache_hit_out,
  output logic [31:0]      bus_data_out,
  output logic             flush_out,
  output logic             snoop_done,
  output logic             snoop_busy,
  output logic             proto_err,
  output logic             lkp_en,
  output logic [IDX_W-1:0] lkp_index,
  input  logic [TAG_W-1:0] lkp_tag_in,
  input  logic [1:0]       lkp_state_in,
  input  logic [31:0]      lkp_data_in,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_index,
  output logic [1:0]       upd_state
);

  snp_state_t       state_reg;
  bus_op_t          op_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             hit_reg;
  logic [31:0]      data_reg;
  logic             flush_reg;
  logic             done_reg;
  logic             busy_reg;
  logic             err_reg;
  logic             upd_en_reg;
  logic [IDX_W-1:0] upd_index_reg;
  mesi_t            upd_state_reg;

  bus_op_t   op_in;
  mesi_t     lkp_state;
  mesi_res_t res;
  logic      start;
  logic      lkp_hit;
  logic      unused_addr_bits;

  assign op_in            = bus_op_t'(bus_operation_in);
  assign lkp_state        = mesi_t'(lkp_state_in);
  assign unused_addr_bits = ^bus_address_in[1:0];

  // The read strobe must be combinational so the array answers while in LOOKUP.
  assign start     = reset && !grant && (state_reg == SNP_IDLE) && (op_in != NOP);
  assign lkp_en    = start;
  assign lkp_index = start ? bus_address_in[IDX_W+1:2] : '0;

  assign lkp_hit = (lkp_tag_in == tag_reg) && (lkp_state != MESI_I);
  assign res     = mesi_next(op_reg, lkp_state);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= SNP_IDLE;
      op_reg        <= NOP;
      tag_reg       <= '0;
      idx_reg       <= '0;
      hit_reg       <= 1'b0;
      data_reg      <= '0;
      flush_reg     <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      upd_en_reg    <= 1'b0;
      upd_index_reg <= '0;
      upd_state_reg <= MESI_I;
    end else begin
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      upd_en_reg    <= 1'b0;
      upd_index_reg <= '0;
      upd_state_reg <= MESI_I;
      case (state_reg)
        SNP_IDLE: begin
          if (start) begin
            op_reg    <= op_in;
            tag_reg   <= bus_address_in[31:IDX_W+2];
            idx_reg   <= bus_address_in[IDX_W+1:2];
            busy_reg  <= 1'b1;
            state_reg <= SNP_LOOKUP;
          end
        end
        SNP_LOOKUP: begin
          if (grant) begin
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= SNP_IDLE;
          end else begin
            hit_reg   <= lkp_hit;
            data_reg  <= lkp_hit ? lkp_data_in : '0;
            flush_reg <= lkp_hit && res.flush;
            err_reg   <= lkp_hit && res.err;
            done_reg  <= 1'b1;
            if (lkp_hit && (res.new_state != lkp_state)) begin
              upd_en_reg    <= 1'b1;
              upd_index_reg <= idx_reg;
              upd_state_reg <= res.new_state;
            end
            state_reg <= SNP_RESPOND;
          end
        end
        SNP_RESPOND: begin
          busy_reg <= 1'b0;
          if (grant) begin
            hit_reg   <= 1'b0;
            data_reg  <= '0;
            flush_reg <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= SNP_IDLE;
          end else begin
            state_reg <= SNP_RELEASE;
          end
        end
        SNP_RELEASE: begin
          // A persisting op is never re-snooped; wait for the bus to go idle.
          if (op_in == NOP) begin
            hit_reg   <= 1'b0;
            data_reg  <= '0;
            flush_reg <= 1'b0;
            state_reg <= SNP_IDLE;
          end
        end
        default: state_reg <= SNP_IDLE;
      endcase
    end
  end

  assign cache_hit_out = hit_reg;
  assign bus_data_out  = data_reg;
  assign flush_out     = flush_reg;
  assign snoop_done    = done_reg;
  assign snoop_busy    = busy_reg;
  assign proto_err     = err_reg;
  // A grant arriving during the response cycle still suppresses the state write.
  assign upd_en        = upd_en_reg && !grant;
  assign upd_index     = upd_index_reg;
  assign upd_state     = upd_state_reg;

endmodule

// File: tb/tb_snoop_responder.sv
// Randomized bench for snoop_responder: a transaction-level MESI model predicts the
// per-cycle output waveform, a single compare process checks it every cycle.
module tb_snoop_responder;

  localparam int SETS  = 64;
  localparam int IDX_W = 6;
  localparam int TAG_W = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             grant = 1'b0;
  logic [1:0]       bus_operation_in = 2'b00;
  logic [31:0]      bus_address_in = 32'h0;
  logic             cache_hit_out, flush_out, snoop_done, snoop_busy, proto_err, lkp_en, upd_en;
  logic [31:0]      bus_data_out;
  logic [IDX_W-1:0] lkp_index, upd_index;
  logic [TAG_W-1:0] lkp_tag_in = '0;
  logic [1:0]       lkp_state_in = 2'b00;
  logic [31:0]      lkp_data_in = 32'h0;
  logic [1:0]       upd_state;

  always #5 clk = ~clk;

  snoop_responder #(.SETS(SETS)) dut (
    .clk(clk), .reset(reset), .grant(grant),
    .bus_operation_in(bus_operation_in), .bus_address_in(bus_address_in),
    .cache_hit_out(cache_hit_out), .bus_data_out(bus_data_out), .flush_out(flush_out),
    .snoop_done(snoop_done), .snoop_busy(snoop_busy), .proto_err(proto_err),
    .lkp_en(lkp_en), .lkp_index(lkp_index),
    .lkp_tag_in(lkp_tag_in), .lkp_state_in(lkp_state_in), .lkp_data_in(lkp_data_in),
    .upd_en(upd_en), .upd_index(upd_index), .upd_state(upd_state)
  );

  // Cache array environment: synchronous read, state written by the DUT.
  logic [TAG_W-1:0] env_tag [SETS];
  logic [1:0]       env_st  [SETS];
  logic [31:0]      env_data[SETS];
  logic             ld_en = 1'b0;
  logic [IDX_W-1:0] ld_idx = '0;
  logic [TAG_W-1:0] ld_tag = '0;
  logic [1:0]       ld_st = 2'b00;
  logic [31:0]      ld_data = 32'h0;

  always @(posedge clk) begin
    if (ld_en) begin
      env_tag[ld_idx]  <= ld_tag;
      env_st[ld_idx]   <= ld_st;
      env_data[ld_idx] <= ld_data;
    end
    if (lkp_en) begin
      lkp_tag_in   <= env_tag[lkp_index];
      lkp_state_in <= env_st[lkp_index];
      lkp_data_in  <= env_data[lkp_index];
    end
    if (upd_en) env_st[upd_index] <= upd_state;
  end

  // Reference copy of the cache contents, evolved only by the model.
  logic [TAG_W-1:0] ref_tag [SETS];
  logic [1:0]       ref_st  [SETS];
  logic [31:0]      ref_data[SETS];

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  bit chk_on = 1'b0;

  logic             e_hit, e_flush, e_done, e_busy, e_perr, e_lkp, e_upd;
  logic [31:0]      e_data;
  logic [IDX_W-1:0] e_lidx, e_uidx;
  logic [1:0]       e_ust;

  logic             cap_hit, cap_flush, cap_done, cap_perr, cap_upd;
  logic [31:0]      cap_data;
  logic [IDX_W-1:0] cap_uidx;
  logic [1:0]       cap_ust;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cache_hit_out", cache_hit_out, e_hit);
      chk("bus_data_out", bus_data_out, e_data);
      chk("flush_out", flush_out, e_flush);
      chk("snoop_done", snoop_done, e_done);
      chk("snoop_busy", snoop_busy, e_busy);
      chk("proto_err", proto_err, e_perr);
      chk("lkp_en", lkp_en, e_lkp);
      chk("lkp_index", lkp_index, e_lidx);
      chk("upd_en", upd_en, e_upd);
      chk("upd_index", upd_index, e_uidx);
      chk("upd_state", upd_state, e_ust);
      if (snoop_done) n_done++;
    end
  end

  task automatic clr_exp();
    e_hit = 0; e_flush = 0; e_done = 0; e_busy = 0; e_perr = 0; e_lkp = 0; e_upd = 0;
    e_data = 0; e_lidx = 0; e_uidx = 0; e_ust = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [TAG_W-1:0] t, input logic [1:0] st,
                      input logic [31:0] d);
    ref_tag[idx] = t; ref_st[idx] = st; ref_data[idx] = d;
    ld_en = 1; ld_idx = idx[IDX_W-1:0]; ld_tag = t; ld_st = st; ld_data = d;
    step();
    ld_en = 0;
  endtask

  function automatic logic [31:0] mkaddr(input int t, input int idx);
    return (32'(t) << (IDX_W + 2)) | (32'(idx) << 2);
  endfunction

  // kind: 0 normal snoop, 1 op while grant held, 2 grant raised in LOOKUP, 3 reset in LOOKUP
  task automatic txn(input int kind, input logic [1:0] op, input logic [31:0] addr,
                     input int hold, input bit swap);
    logic [TAG_W-1:0] t;
    logic [IDX_W-1:0] i;
    logic [1:0]       old, nw, op2;
    bit               hit, fl, er, up;
    int               last, d0;
    t   = addr[31:IDX_W+2];
    i   = addr[IDX_W+1:2];
    old = ref_st[i];
    hit = (ref_tag[i] == t) && (old != 2'b00);
    nw = old; fl = 0; er = 0;
    if (hit) begin
      nw = (op == 2'b01) ? 2'b01 : 2'b00;
      fl = (old == 2'b11) && (op != 2'b11);
      er = (op == 2'b11) && (old >= 2'b10);
    end
    up  = hit && (nw != old);
    op2 = 2'(op % 3 + 1);
    d0  = n_done;
    bus_address_in = addr;
    if (kind == 0) begin
      last = ((hold > 3) ? hold : 3) + 1;
      for (int c = 0; c <= last; c++) begin
        clr_exp();
        bus_operation_in = (c < hold) ? ((c > 0 && swap) ? op2 : op) : 2'b00;
        if (c == 0) begin
          e_lkp = 1; e_lidx = i;
        end else if (c == 1) begin
          e_busy = 1;
        end else if (c == 2) begin
          e_busy = 1; e_done = 1; e_hit = hit; e_data = hit ? ref_data[i] : 0;
          e_flush = fl; e_perr = er; e_upd = up;
          e_uidx = up ? i : '0; e_ust = up ? nw : 2'b00;
          cap_hit = cache_hit_out; cap_data = bus_data_out; cap_flush = flush_out;
          cap_done = snoop_done; cap_perr = proto_err; cap_upd = upd_en;
          cap_uidx = upd_index; cap_ust = upd_state;
        end else if (c < last) begin
          e_hit = hit; e_data = hit ? ref_data[i] : 0; e_flush = fl;
        end
        step();
      end
      chk("done_pulses", 32'(n_done - d0), 32'd1);
      if (up) ref_st[i] = nw;
      $display("txn snoop op=%0d addr=%h hold=%0d hit=%0b new_state=%0d", op, addr, hold, hit, nw);
    end else if (kind == 1) begin
      clr_exp(); grant = 1; bus_operation_in = op; step();
      clr_exp(); step();
      clr_exp(); grant = 0; bus_operation_in = 2'b00; step();
      chk("done_pulses", 32'(n_done - d0), 32'd0);
      $display("txn granted-ignore op=%0d addr=%h", op, addr);
    end else begin
      clr_exp(); bus_operation_in = op; e_lkp = 1; e_lidx = i; step();
      clr_exp(); e_busy = 1; bus_operation_in = 2'b00;
      if (kind == 2) grant = 1; else reset = 0;
      step();
      clr_exp(); reset = 1; e_perr = (kind == 2); step();
      clr_exp(); grant = 0; step();
      chk("done_pulses", 32'(n_done - d0), 32'd0);
      $display("txn %s op=%0d addr=%h", (kind == 2) ? "grant-abort" : "reset-abort", op, addr);
    end
  endtask

  initial begin
    clr_exp();
    reset = 0;
    step();
    chk_on = 1;
    for (int k = 0; k < SETS; k++)
      load(k, TAG_W'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
    load(5, 24'h1, 2'b11, 32'hDEADBEEF);
    load(9, 24'h2, 2'b10, 32'h12345678);
    load(20, 24'h1, 2'b01, 32'hCAFEF00D);
    load(12, 24'h3, 2'b11, 32'hA5A5A5A5);
    step();
    reset = 1;
    step();

    // M line read by the other core: flush and downgrade to S.
    txn(0, 2'b01, mkaddr(1, 5), 1, 0);
    chk("pin_rd_hit", cap_hit, 1);
    chk("pin_rd_data", cap_data, 32'hDEADBEEF);
    chk("pin_rd_flush", cap_flush, 1);
    chk("pin_rd_upd", cap_upd, 1);
    chk("pin_rd_uidx", cap_uidx, 5);
    chk("pin_rd_ust", cap_ust, 2'b01);
    chk("pin_rd_done", cap_done, 1);

    // RDX on an E line, op held five extra cycles.
    txn(0, 2'b10, mkaddr(2, 9), 6, 0);
    chk("pin_rdx_hit", cap_hit, 1);
    chk("pin_rdx_flush", cap_flush, 0);
    chk("pin_rdx_ust", cap_ust, 2'b00);
    chk("pin_rdx_upd", cap_upd, 1);

    // Tag mismatch on a valid line, then a hit-tag on an invalidated line.
    txn(0, 2'b01, mkaddr(2, 20), 2, 0);
    chk("pin_miss_hit", cap_hit, 0);
    chk("pin_miss_data", cap_data, 0);
    chk("pin_miss_upd", cap_upd, 0);
    chk("pin_miss_done", cap_done, 1);
    txn(0, 2'b01, mkaddr(2, 9), 1, 0);
    chk("pin_inv_hit", cap_hit, 0);

    // Upgrade against a modified line is a protocol error.
    txn(0, 2'b11, mkaddr(3, 12), 1, 0);
    chk("pin_upgr_perr", cap_perr, 1);
    chk("pin_upgr_ust", cap_ust, 2'b00);
    chk("pin_upgr_upd", cap_upd, 1);

    txn(1, 2'b11, mkaddr(3, 12), 1, 0);
    txn(3, 2'b10, mkaddr(1, 5), 1, 0);
    // Line 5 must still be S after the aborted RDX.
    txn(0, 2'b10, mkaddr(1, 5), 1, 0);
    chk("pin_after_rst_hit", cap_hit, 1);
    chk("pin_after_rst_ust", cap_ust, 2'b00);
    txn(2, 2'b01, mkaddr(1, 20), 1, 0);

    for (int n = 0; n < 300; n++) begin
      int kind, r, idx, tg;
      r    = $urandom_range(0, 9);
      kind = (r < 7) ? 0 : (r - 6);
      idx  = $urandom_range(0, SETS - 1);
      tg   = ($urandom_range(0, 9) < 6) ? int'(ref_tag[idx]) : $urandom_range(0, 3);
      txn(kind, 2'($urandom_range(1, 3)), mkaddr(tg, idx) | 32'($urandom_range(0, 3)),
          $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
